nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_if.sv | 26 ++
 rtl/nibble_serial_adder.sv | 127 ++++++++++++
 tb/tb_nibble_serial_adder.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// Handshake and operand/result bus for nibble_serial_adder.
// "master" drives operands and takes results; "slave" is the adder.
interface nibble_serial_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, overflow
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, overflow
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one 4-bit ripple slice per clock, with the
// carry held in a register between slices and valid/ready on both sides.
module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  nibble_serial_adder_if.slave bus
);
  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 8) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 8");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_last;
  logic [WIDTH-1:0] w_a_shift;
  logic [WIDTH-1:0] w_b_shift;
  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [3:0]       w_nib_sum;
  logic [4:0]       w_c;

  assign w_last    = (r_idx == IDXW'(NIB - 1));
  assign w_a_shift = r_a >> {r_idx, 2'b00};
  assign w_b_shift = r_b >> {r_idx, 2'b00};
  assign w_a_nib   = w_a_shift[3:0];
  assign w_b_nib   = w_b_shift[3:0];

  // w_c[3] is the carry into the slice MSB; on the last step that is the
  // carry into bit WIDTH-1, which the signed-overflow flag needs.
  always_comb begin
    w_c       = '0;
    w_nib_sum = '0;
    w_c[0]    = r_carry;
    for (int unsigned i = 0; i < 4; i++) begin
      w_nib_sum[i] = w_a_nib[i] ^ w_b_nib[i] ^ w_c[i];
      w_c[i+1]     = (w_a_nib[i] & w_b_nib[i]) | (w_c[i] & (w_a_nib[i] ^ w_b_nib[i]));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
            r_sum   <= '0;
          end
        end
        RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_nib_sum;
          r_carry                    <= w_c[4];
          r_idx                      <= r_idx + IDXW'(1);
          if (w_last) begin
            r_cout <= w_c[4];
            r_ovf  <= w_c[3] ^ w_c[4];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.overflow  = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16): directed vector
// table, backpressure, reset abort and a random streaming run.
module tb_nibble_serial_adder;
  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_adder_if #(.WIDTH(W)) bus ();

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic; returns {overflow, cout, sum}.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
    logic [W:0] t;
    logic       ovf;
    t   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return {ovf, t[W], t[W-1:0]};
  endfunction

  // Present operands, wait for accept, scramble inputs, then wait for out_valid.
  task automatic run_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         output logic [W-1:0] s, output logic c, output logic o,
                         output int lat);
    int n;
    @(negedge clk);
    bus.a = a; bus.b = b; bus.cin = cin; bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a = W'($urandom); bus.b = W'($urandom); bus.cin = 1'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.out_valid && lat < 20);
    s = bus.sum; c = bus.cout; o = bus.overflow;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs[7];
    logic [W-1:0]  s, s_hold;
    logic          c, o, c_hold, o_hold;
    logic [W+1:0]  r;
    int            lat;
    int unsigned   t_prev;
    logic [W-1:0]  qa[$], qb[$];
    logic          qc[$];

    vecs[0] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_sum", 32'(bus.sum), 32'd0);
    chk("reset_cout", 32'(bus.cout), 32'd0);
    chk("reset_ovf", 32'(bus.overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with in_valid low: nothing happens.
    repeat (3) begin
      @(posedge clk); #1;
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
      chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
    end

    // Directed table, out_ready held high.
    for (int i = 0; i < 7; i++) begin
      run_add(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, o, lat);
      chk("vec_latency", 32'(lat), 32'd4);
      chk("vec_sum", 32'(s), 32'(vecs[i].exp_sum));
      chk("vec_cout", 32'(c), 32'(vecs[i].exp_cout));
      chk("vec_ovf", 32'(o), 32'(vecs[i].exp_ovf));
      r = ref_add(vecs[i].a, vecs[i].b, vecs[i].cin);
      chk("vec_model", 32'(s), 32'(r[W-1:0]));
      @(posedge clk); #1;
      chk("vec_release_in_ready", 32'(bus.in_ready), 32'd1);
      chk("vec_release_out_valid", 32'(bus.out_valid), 32'd0);
    end

    // Backpressure: result must hold while out_ready is low.
    bus.out_ready = 1'b0;
    run_add(16'h00FF, 16'h0F01, 1'b0, s_hold, c_hold, o_hold, lat);
    r = ref_add(16'h00FF, 16'h0F01, 1'b0);
    chk("bp_sum", 32'(s_hold), 32'(r[W-1:0]));
    chk("bp_cout", 32'(c_hold), 32'(r[W]));
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_sum_stable", 32'(bus.sum), 32'(r[W-1:0]));
      chk("bp_cout_stable", 32'(bus.cout), 32'(r[W]));
      chk("bp_ovf_stable", 32'(bus.overflow), 32'(r[W+1]));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);

    // Reset in the second RUN cycle aborts the add.
    @(negedge clk);
    bus.a = 16'h1111; bus.b = 16'h2222; bus.cin = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_sum", 32'(bus.sum), 32'd0);
    chk("abort_cout", 32'(bus.cout), 32'd0);
    chk("abort_ovf", 32'(bus.overflow), 32'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("abort_no_result", 32'(bus.out_valid), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      chk("post_abort_idle", 32'(bus.out_valid), 32'd0);
    end
    run_add(16'hA5A5, 16'h5A5A, 1'b1, s, c, o, lat);
    r = ref_add(16'hA5A5, 16'h5A5A, 1'b1);
    chk("post_abort_latency", 32'(lat), 32'd4);
    chk("post_abort_sum", 32'(s), 32'(r[W-1:0]));
    chk("post_abort_cout", 32'(c), 32'(r[W]));
    chk("post_abort_ovf", 32'(o), 32'(r[W+1]));
    @(posedge clk); #1;

    // Streaming: in_valid and out_ready held high, 20 random operand pairs.
    for (int i = 0; i < 21; i++) begin
      qa.push_back(W'($urandom));
      qb.push_back(W'($urandom));
      qc.push_back(1'($urandom));
    end
    @(negedge clk);
    bus.a = qa[0]; bus.b = qb[0]; bus.cin = qc[0];
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    t_prev = 0;
    for (int i = 0; i < 20; i++) begin
      lat = 0;
      do begin
        @(posedge clk); #1;
        lat++;
      end while (!bus.out_valid && lat < 20);
      chk("stream_result_seen", 32'(bus.out_valid), 32'd1);
      r = ref_add(qa[i], qb[i], qc[i]);
      chk("stream_sum", 32'(bus.sum), 32'(r[W-1:0]));
      chk("stream_cout", 32'(bus.cout), 32'(r[W]));
      chk("stream_ovf", 32'(bus.overflow), 32'(r[W+1]));
      if (i > 0) chk("stream_period", cyc - t_prev, 32'd6);
      t_prev = cyc;
      if (i < 19) begin
        bus.a = qa[i+1]; bus.b = qb[i+1]; bus.cin = qc[i+1];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    chk("stream_end_idle", 32'(bus.in_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
